// File: rtl/vid_line_fetch.sv
// vid_line_fetch: streams a run of bytes from one RAM read port into a show-ahead FIFO
// and presents them to the pixel pipeline over valid/ready.
// Optional feature: define VID_LINE_FETCH_STRIDE_EN to add a per-line address stride input.
module vid_line_fetch #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [7:0]  len,
`ifdef VID_LINE_FETCH_STRIDE_EN
  input  logic [7:0]  stride,
`endif
  input  logic        mem_grant,
  output logic [15:0] mem_addr,
  output logic        mem_wena,
  input  logic [7:0]  mem_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e state_q, state_d;

  logic [7:0]      fifo_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [15:0]     mem_addr_q;
  logic [8:0]      remaining_q;
  logic [7:0]      out_data_q, head_d;
  logic            out_valid_q;
  logic            busy_q;
  logic            done_q;
  logic [15:0]     step;

  logic load, push, pop, finish, full;

`ifdef VID_LINE_FETCH_STRIDE_EN
  logic [7:0] stride_q;
  assign step = {8'h00, stride_q};
`else
  assign step = 16'd1;
`endif

  // Consumer handshake only steers FIFO control; every output below is a register.
  assign pop  = out_valid_q & out_ready;
  assign full = (count_q == CntW'(DEPTH));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load) state_d = StFetch;
      StFetch: if (push && remaining_q == 9'd1) state_d = StDrain;
      StDrain: if (finish) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control decode; push is refused when full even if a pop frees a slot this cycle.
  always_comb begin
    load   = (state_q == StIdle) && start;
    push   = (state_q == StFetch) && mem_grant && !full;
    finish = (state_q == StDrain) && pop && (count_q == CntW'(1));
  end

  // FIFO pointer/count update and the next show-ahead head byte.
  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // The new head may be the byte being written right now (empty FIFO, or last entry popped).
    if (count_d == '0) begin
      head_d = out_data_q;
    end else if (push && (rd_ptr_d == wr_ptr_q)) begin
      head_d = mem_data;
    end else begin
      head_d = fifo_q[rd_ptr_d];
    end
  end

  // FIFO storage; contents are meaningless while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= mem_data;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      mem_addr_q  <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef VID_LINE_FETCH_STRIDE_EN
      stride_q    <= '0;
`endif
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_data_q  <= head_d;
      out_valid_q <= (count_d != '0);
      done_q      <= finish;
      if (load) begin
        mem_addr_q  <= base_addr;
        remaining_q <= (len == 8'd0) ? 9'd256 : {1'b0, len};
        busy_q      <= 1'b1;
`ifdef VID_LINE_FETCH_STRIDE_EN
        stride_q    <= stride;
`endif
      end else begin
        if (push) begin
          mem_addr_q  <= mem_addr_q + step;
          remaining_q <= remaining_q - 9'd1;
        end
        if (finish) begin
          busy_q <= 1'b0;
        end
      end
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wena  = 1'b0;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vid_line_fetch.sv
// Scoreboard bench for vid_line_fetch: stimulus queues expected bytes, a monitor pops and compares.
module tb_vid_line_fetch;

  logic        clk = 1'b0;
  logic        reset, start, mem_grant, out_ready;
  logic [15:0] base_addr;
  logic [7:0]  len, stride;
  logic [15:0] mem_addr;
  logic        mem_wena, out_valid, busy, done;
  logic [7:0]  mem_data, out_data;

  logic [7:0]  ram [0:65535];
  logic [7:0]  exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;
  logic        pend_done = 1'b0;

  assign mem_data = ram[mem_addr];

  always #5 clk = ~clk;

  vid_line_fetch #(.DEPTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
`ifdef VID_LINE_FETCH_STRIDE_EN
    .stride    (stride),
`endif
    .mem_grant (mem_grant),
    .mem_addr  (mem_addr),
    .mem_wena  (mem_wena),
    .mem_data  (mem_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every popped byte and the done pulse one cycle after the last pop.
  always @(negedge clk) begin
    if (mon_en) begin
      check("done_pulse", done, pend_done);
      pend_done = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", out_data, 32'hFFFF_FFFF);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
          if (exp_q.size() == 0) pend_done = 1'b1;
        end
      end
    end
  end

  // Issue a start at the current cycle; queue the bytes the line should produce if accepted.
  task automatic do_start(input logic [15:0] b, input logic [7:0] l, input logic [7:0] s,
                          input bit accept);
    int n;
    n = (l == 8'd0) ? 256 : int'(l);
    if (accept) begin
      for (int i = 0; i < n; i++) exp_q.push_back(ram[16'(int'(b) + i * int'(s))]);
    end
    base_addr = b;
    len       = l;
    stride    = s;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (accept) begin
      check("busy_after_start", busy, 1);
      check("addr_after_start", mem_addr, b);
    end
  endtask

  task automatic wait_idle(input int budget, input string name, output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (busy !== 1'b0) check(name, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    int fetched;
    logic g;
    logic [15:0] a, ea;

    for (int i = 0; i < 65536; i++) ram[i] = 8'(i) ^ 8'(i >> 8);
    for (int i = 0; i < 256; i++) ram[16'h0400 + i] = 8'(i);

    reset = 1'b1; start = 1'b0; mem_grant = 1'b1; out_ready = 1'b1;
    base_addr = '0; len = '0; stride = 8'd1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wena", mem_wena, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Basic line: 40 bytes at one per cycle, busy falls with done one cycle after last pop.
    do_start(16'h0400, 8'd40, 8'd1, 1'b1);
    wait_idle(200, "basic_timeout", cyc);
    check("basic_cycles", cyc, 41);
    check("basic_done_with_busy_fall", done, 1);
    check("basic_wena", mem_wena, 0);

    // Wrap with len=0, started in the done cycle of the previous line.
    do_start(16'hFFF0, 8'd0, 8'd1, 1'b1);
    wait_idle(600, "wrap_timeout", cyc);
    check("wrap_cycles", cyc, 257);
    check("wrap_final_addr", mem_addr, 16'h00F0);

    // Backpressure: FIFO fills to 16 and fetch stalls.
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_start(16'h2000, 8'd20, 8'd1, 1'b1);
    repeat (30) begin @(posedge clk); #1; end
    check("bp_addr_hold", mem_addr, 16'h2010);
    check("bp_valid", out_valid, 1);
    check("bp_busy", busy, 1);
    out_ready = 1'b1;
    wait_idle(200, "bp_timeout", cyc);
    check("bp_final_addr", mem_addr, 16'h2014);

    // Grant toggling every cycle: address advances only on granted cycles.
    @(posedge clk); #1;
    do_start(16'h3000, 8'd10, 8'd1, 1'b1);
    fetched = 0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 60) begin
      g = mem_grant;
      a = mem_addr;
      @(posedge clk); #1;
      cyc++;
      ea = a;
      if (g && fetched < 10) begin
        ea = a + 16'd1;
        fetched++;
      end
      check("stall_addr", mem_addr, ea);
      mem_grant = ~mem_grant;
    end
    check("stall_cycles", cyc, 20);
    check("stall_busy_end", busy, 0);
    mem_grant = 1'b1;

    // Reset mid-line with 5 bytes held, then restart and an ignored start while busy.
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_start(16'h5000, 8'd30, 8'd1, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    mem_grant = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_addr", mem_addr, 16'h5005);
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_done", done, 0);
    reset = 1'b0;
    mem_grant = 1'b1;
    out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("post_rst_valid", out_valid, 0);
    do_start(16'h6000, 8'd12, 8'd1, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    do_start(16'h7000, 8'd5, 8'd1, 1'b0);
    wait_idle(100, "restart_timeout", cyc);
    check("restart_final_addr", mem_addr, 16'h600C);
    repeat (3) begin @(posedge clk); #1; end
    check("restart_idle_valid", out_valid, 0);
    check("restart_idle_busy", busy, 0);

`ifdef VID_LINE_FETCH_STRIDE_EN
    // Stride: addresses step by 40 per fetch.
    do_start(16'h1000, 8'd8, 8'd40, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      check("stride_addr", mem_addr, 16'h1000 + 16'(40 * k));
    end
    wait_idle(100, "stride_timeout", cyc);
`endif

    repeat (3) begin @(posedge clk); #1; end
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
